da_fir_sequencer: RTL and testbench

Control sequencer for the 64-tap, 16-bit distributed-arithmetic FIR datapath. It accepts a frame of TAPS input samples over a valid/ready handshake and steers their writes into the sample register bank. It then walks the four DA lookup tables bit-plane by bit-plane, driving accumulator clear, enable, shift and subtract controls. Finally it holds the completed sum valid until the consumer accepts it. It contains the control logic only; the sample bank, the LUTs and the 38-bit accumulator are external.

---
 rtl/da_fir_sequencer.sv | 93 +++++++++
 tb/tb_da_fir_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/da_fir_sequencer.sv
// da_fir_sequencer: load/compute/hold sequencer for a 64-tap distributed-arithmetic FIR datapath.
// Optional FIR_SEQ_STAT_EN adds a 16-bit frame_cnt output counting result handshakes.
module da_fir_sequencer #(
    parameter int TAPS   = 64,
    parameter int GROUPS = 4,
    parameter int DW     = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      wr_en,
    output logic [$clog2(TAPS)-1:0]   wr_addr,
    output logic                      lut_en,
    output logic [$clog2(GROUPS)-1:0] lut_grp,
    output logic [$clog2(DW)-1:0]     lut_bit,
    output logic                      acc_clr,
    output logic                      acc_en,
    output logic [$clog2(DW)-1:0]     acc_shift,
    output logic                      acc_sub,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic                      busy
`ifdef FIR_SEQ_STAT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);
    localparam int AW = $clog2(TAPS);
    localparam int BW = $clog2(DW);

    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, HOLD} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    // cnt is the sample address while loading and the step index k while computing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        in_ready  = state == IDLE || state == LOAD;
        wr_en     = in_valid && in_ready;
        wr_addr   = in_ready ? cnt : '0;
        lut_en    = state == COMPUTE;
        lut_grp   = lut_en ? cnt[AW-1:BW] : '0;
        lut_bit   = lut_en ? cnt[BW-1:0] : '0;
        acc_clr   = lut_en && cnt == '0;
        res_valid = state == HOLD;
        busy      = state != IDLE;
        case (state)
            IDLE, LOAD: if (wr_en) begin
                cnt_nxt   = cnt == AW'(TAPS-1) ? '0 : cnt + 1'b1;
                state_nxt = cnt == AW'(TAPS-1) ? COMPUTE : LOAD;
            end
            COMPUTE: begin
                cnt_nxt   = cnt == AW'(GROUPS*DW-1) ? '0 : cnt + 1'b1;
                state_nxt = cnt == AW'(GROUPS*DW-1) ? DRAIN : COMPUTE;
            end
            DRAIN:   state_nxt = HOLD;
            HOLD:    state_nxt = res_ready ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    // accumulate controls trail the LUT by its one-cycle register latency
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc_en    <= 1'b0;
            acc_shift <= '0;
            acc_sub   <= 1'b0;
        end else begin
            acc_en    <= lut_en;
            acc_shift <= lut_bit;
            acc_sub   <= lut_en && lut_bit == BW'(DW-1);
        end

`ifdef FIR_SEQ_STAT_EN
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            frame_cnt <= '0;
        else if (res_valid && res_ready)
            frame_cnt <= frame_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_da_fir_sequencer.sv
// tb_da_fir_sequencer: randomized frame-level checks of da_fir_sequencer against a cycle-count model.
module tb_da_fir_sequencer;
    localparam int TAPS = 64, GROUPS = 4, DW = 16;

    logic       clk = 1'b0, reset = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
    logic       in_ready, wr_en, lut_en, acc_clr, acc_en, acc_sub, res_valid, busy;
    logic [5:0] wr_addr;
    logic [1:0] lut_grp;
    logic [3:0] lut_bit, acc_shift;
`ifdef FIR_SEQ_STAT_EN
    logic [15:0] frame_cnt;
`endif
    int errors = 0, checks = 0, frames = 0;

    da_fir_sequencer #(.TAPS(TAPS), .GROUPS(GROUPS), .DW(DW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en),
        .wr_addr(wr_addr), .lut_en(lut_en), .lut_grp(lut_grp), .lut_bit(lut_bit),
        .acc_clr(acc_clr), .acc_en(acc_en), .acc_shift(acc_shift), .acc_sub(acc_sub),
        .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
`ifdef FIR_SEQ_STAT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_reset_values(input string tag);
        checks++;
        if ({in_ready, wr_en, wr_addr, lut_en, lut_grp, lut_bit, acc_clr, acc_en, acc_shift, acc_sub, res_valid, busy}
            !== {1'b1, 1'b0, 6'd0, 1'b0, 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: rdy=%b wr=%b addr=%0d lut=%b grp=%0d bit=%0d clr=%b en=%b sh=%0d sub=%b rv=%b busy=%b, want 1 0 0 0 0 0 0 0 0 0 0 0",
                     tag, in_ready, wr_en, wr_addr, lut_en, lut_grp, lut_bit, acc_clr, acc_en, acc_shift, acc_sub, res_valid, busy);
        end
    endtask

    // load one frame; gap_pct is the chance of in_valid=0 on a given cycle
    task automatic do_load(input int gap_pct);
        int beats = 0, cyc = 0;
        while (beats < TAPS && cyc < 2000) begin
            @(negedge clk);
            in_valid = $urandom_range(99) >= gap_pct;
            res_ready = 1'($urandom);
            #1;
            checks++;
            if (in_ready !== 1'b1 || wr_en !== in_valid || busy !== (beats != 0) || lut_en !== 1'b0 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL load_ctl beat%0d: rdy=%b wr=%b busy=%b lut=%b rv=%b, want 1 %b %b 0 0",
                         beats, in_ready, wr_en, busy, lut_en, res_valid, in_valid, beats != 0);
            end
            if (in_valid) begin
                checks++;
                if (wr_addr !== 6'(beats)) begin
                    errors++;
                    $display("FAIL load_addr: wr_addr=%0d want %0d", wr_addr, beats);
                end
                beats++;
            end
            cyc++;
        end
        checks++;
        if (beats != TAPS) begin
            errors++;
            $display("FAIL load_timeout: beats=%0d want %0d", beats, TAPS);
        end
    endtask

    // check compute steps k=0..nk-1
    task automatic do_compute(input int nk);
        for (int k = 0; k < nk; k++) begin
            @(negedge clk);
            in_valid = 1'($urandom);
            res_ready = 1'($urandom);
            #1;
            checks++;
            if (lut_en !== 1'b1 || lut_grp !== 2'(k / DW) || lut_bit !== 4'(k % DW) || acc_clr !== (k == 0)
                || acc_en !== (k > 0) || acc_shift !== (k > 0 ? 4'((k - 1) % DW) : 4'd0)
                || acc_sub !== (k > 0 && (k - 1) % DW == DW - 1)
                || in_ready !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL compute k=%0d: lut=%b grp=%0d bit=%0d clr=%b en=%b sh=%0d sub=%b rdy=%b wr=%b busy=%b rv=%b",
                         k, lut_en, lut_grp, lut_bit, acc_clr, acc_en, acc_shift, acc_sub, in_ready, wr_en, busy, res_valid);
            end
        end
    endtask

    task automatic do_hold(input int stall);
        @(negedge clk);
        in_valid = 1'($urandom);
        res_ready = 1'($urandom);
        #1;
        checks++;
        if (lut_en !== 1'b0 || acc_en !== 1'b1 || acc_shift !== 4'd15 || acc_sub !== 1'b1 || res_valid !== 1'b0
            || busy !== 1'b1 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL drain: lut=%b en=%b sh=%0d sub=%b rv=%b busy=%b wr=%b, want 0 1 15 1 0 1 0",
                     lut_en, acc_en, acc_shift, acc_sub, res_valid, busy, wr_en);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            res_ready = 1'b0;
            in_valid = 1'b1;
            #1;
            checks++;
            if (res_valid !== 1'b1 || in_ready !== 1'b0 || wr_en !== 1'b0 || acc_en !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL hold_stall %0d: rv=%b rdy=%b wr=%b en=%b busy=%b, want 1 0 0 0 1",
                         i, res_valid, in_ready, wr_en, acc_en, busy);
            end
        end
        @(negedge clk);
        res_ready = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold_valid: res_valid=%b want 1", res_valid);
        end
        frames++;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || wr_addr !== 6'd0) begin
            errors++;
            $display("FAIL hold_exit: rv=%b busy=%b rdy=%b addr=%0d, want 0 0 1 0", res_valid, busy, in_ready, wr_addr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        in_valid = 1'b0;
        #2;
        check_reset_values("reset_values");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_values("after_release");
    endtask

    task automatic test_back_to_back;
        do_load(0);
        do_compute(GROUPS * DW);
        do_hold(0);
    endtask

    task automatic test_gaps;
        do_load(50);
        do_compute(GROUPS * DW);
        do_hold($urandom_range(3));
    endtask

    task automatic test_hold_stall;
        do_load(20);
        do_compute(GROUPS * DW);
        do_hold(20);
    endtask

    task automatic test_frame_cnt;
`ifdef FIR_SEQ_STAT_EN
        checks++;
        if (frame_cnt !== 16'(frames)) begin
            errors++;
            $display("FAIL frame_cnt: got %0d want %0d", frame_cnt, frames);
        end
`endif
    endtask

    task automatic test_reset_mid_compute;
        do_load(10);
        do_compute(30);
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_values("reset_k30");
        frames = 0;
`ifdef FIR_SEQ_STAT_EN
        checks++;
        if (frame_cnt !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset: got %0d want 0", frame_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_back_to_back();
        test_frame_cnt();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_hold_stall();
        test_frame_cnt();
        test_reset_mid_compute();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
